mem_access_stage: RTL and testbench

- MEM stage of the mips32 pipeline: sits between the EX/MEM and MEM/WB pipeline registers.
- Turns load/store control plus ALU address into a data-bus transaction with req/ack handshake and byte-lane alignment.
- Freezes the pipeline while the bus is busy.
- Delivers a sign/zero-extended load word to the MEM/WB memData input; aluResult bypasses this block.

---
 rtl/mem_access_stage_pkg.sv | 30 +++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_access_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared mips32 MEM-stage definitions: access size codes, FSM states and bus timeout.
// Imported by the MEM stage and its lane-alignment helper.
package mem_access_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } MemState;

  // Size code 2'b11 behaves as a word everywhere, so it shares the word rule
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      SZ_WORD: bad = |addrLo;
      default: bad = |addrLo;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane helper for the MEM stage: store lane replication,
// byte-enable generation and load extract with sign/zero extension.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  storeSize,
  input  logic [1:0]  storeAddrLo,
  input  logic [31:0] storeData,
  output logic [3:0]  byteEn,
  output logic [31:0] laneData,
  input  logic [1:0]  loadSize,
  input  logic [1:0]  loadAddrLo,
  input  logic        loadUnsigned,
  input  logic [31:0] rawData,
  output logic [31:0] loadData
);

  logic [31:0] shifted;

  always_comb begin
    byteEn   = 4'b1111;
    laneData = storeData;
    case (storeSize)
      SZ_BYTE: begin
        byteEn   = 4'b0001 << storeAddrLo;
        laneData = {4{storeData[7:0]}};
      end
      SZ_HALF: begin
        byteEn   = storeAddrLo[1] ? 4'b1100 : 4'b0011;
        laneData = {2{storeData[15:0]}};
      end
      default: begin
        byteEn   = 4'b1111;
        laneData = storeData;
      end
    endcase
  end

  // Little-endian: the addressed lane is moved down to bits [7:0]/[15:0] before extension
  always_comb begin
    shifted  = rawData >> {loadAddrLo, 3'b000};
    loadData = rawData;
    case (loadSize)
      SZ_BYTE: begin
        loadData = {{24{shifted[7] & ~loadUnsigned}}, shifted[7:0]};
      end
      SZ_HALF: begin
        loadData = {{16{shifted[15] & ~loadUnsigned}}, shifted[15:0]};
      end
      default: begin
        loadData = rawData;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mips32 MEM stage: turns EX/MEM load/store control into a req/ack bus transaction,
// freezes the pipeline while the bus is busy and returns the extended load word.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [1:0]  sizeIn,
  input  logic        unsignedIn,
  input  logic [31:0] addrIn,
  input  logic [31:0] storeDataIn,
  output logic        stallOut,
  output logic [31:0] loadDataOut,
  output logic        misalignOut,
  output logic        errOut,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busBe,
  output logic [31:0] busWData,
  input  logic        busAck,
  input  logic [31:0] busRData
);

  MemState     state;
  MemState     nextState;
  logic [7:0]  waitCnt;
  logic [31:0] capData;
  logic        errFlag;
  logic        regRead;
  logic [1:0]  regSize;
  logic [1:0]  regAddrLo;
  logic        regUnsigned;

  logic        access;
  logic        misaligned;
  logic        startAccess;
  logic        timeoutHit;
  logic [3:0]  alignedBe;
  logic [31:0] alignedWData;
  logic [31:0] extendedLoad;

  mem_lane_align uLaneAlign (
    .storeSize    (sizeIn),
    .storeAddrLo  (addrIn[1:0]),
    .storeData    (storeDataIn),
    .byteEn       (alignedBe),
    .laneData     (alignedWData),
    .loadSize     (regSize),
    .loadAddrLo   (regAddrLo),
    .loadUnsigned (regUnsigned),
    .rawData      (capData),
    .loadData     (extendedLoad)
  );

  always_comb begin
    access      = memReadIn | memWriteIn;
    misaligned  = isMisaligned(sizeIn, addrIn[1:0]);
    startAccess = (state == S_IDLE) && access && !misaligned;
    timeoutHit  = (waitCnt == 8'(TIMEOUT - 1)) && !busAck;
    misalignOut = (state == S_IDLE) && access && misaligned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState   = state;
    stallOut    = 1'b0;
    loadDataOut = 32'd0;
    errOut      = 1'b0;
    case (state)
      S_IDLE: begin
        if (startAccess) begin
          stallOut  = 1'b1;
          nextState = S_ACCESS;
        end
      end
      S_ACCESS: begin
        stallOut = 1'b1;
        if (busAck || timeoutHit) begin
          nextState = S_DONE;
        end
      end
      S_DONE: begin
        loadDataOut = regRead ? extendedLoad : 32'd0;
        errOut      = errFlag;
        nextState   = S_IDLE;
      end
      default: begin
        nextState = S_IDLE;
      end
    endcase
  end

  // Bus outputs and load context are captured at accept so they stay stable
  // while the pipeline inputs are frozen and the bus is waiting for ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busReq      <= 1'b0;
      busWe       <= 1'b0;
      busAddr     <= 32'd0;
      busBe       <= 4'd0;
      busWData    <= 32'd0;
      waitCnt     <= 8'd0;
      capData     <= 32'd0;
      errFlag     <= 1'b0;
      regRead     <= 1'b0;
      regSize     <= SZ_BYTE;
      regAddrLo   <= 2'b00;
      regUnsigned <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (startAccess) begin
            busReq      <= 1'b1;
            busWe       <= ~memReadIn;
            busAddr     <= {addrIn[31:2], 2'b00};
            busBe       <= alignedBe;
            busWData    <= alignedWData;
            waitCnt     <= 8'd0;
            errFlag     <= 1'b0;
            regRead     <= memReadIn;
            regSize     <= sizeIn;
            regAddrLo   <= addrIn[1:0];
            regUnsigned <= unsignedIn;
          end
        end
        S_ACCESS: begin
          if (busAck) begin
            busReq  <= 1'b0;
            capData <= busRData;
          end else if (timeoutHit) begin
            busReq  <= 1'b0;
            capData <= 32'd0;
            errFlag <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        S_DONE: begin
          errFlag <= 1'b0;
        end
        default: begin
          busReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// accesses checked against a byte-lane reference model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        memReadIn;
  logic        memWriteIn;
  logic [1:0]  sizeIn;
  logic        unsignedIn;
  logic [31:0] addrIn;
  logic [31:0] storeDataIn;
  logic        stallOut;
  logic [31:0] loadDataOut;
  logic        misalignOut;
  logic        errOut;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWData;
  logic        busAck;
  logic [31:0] busRData;

  int checks;
  int failures;

  int          stallCyc;
  int          reqCyc;
  logic [31:0] obsAddr;
  logic [3:0]  obsBe;
  logic        obsWe;
  logic [31:0] obsWData;
  logic [31:0] obsLoad;
  logic        obsErr;
  logic        obsMis;
  logic        obsStable;
  logic        finished;

  mem_access_stage #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .memReadIn   (memReadIn),
    .memWriteIn  (memWriteIn),
    .sizeIn      (sizeIn),
    .unsignedIn  (unsignedIn),
    .addrIn      (addrIn),
    .storeDataIn (storeDataIn),
    .stallOut    (stallOut),
    .loadDataOut (loadDataOut),
    .misalignOut (misalignOut),
    .errOut      (errOut),
    .busReq      (busReq),
    .busWe       (busWe),
    .busAddr     (busAddr),
    .busBe       (busBe),
    .busWData    (busWData),
    .busAck      (busAck),
    .busRData    (busRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain byte-lane arithmetic on the little-endian word
  function automatic logic refAligned(input logic [1:0] sz, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (sz == SZ_BYTE) return 1'b1;
    if (sz == SZ_HALF) return (a % 2) == 0;
    return a == 0;
  endfunction

  function automatic logic [3:0] refBe(input logic [1:0] sz, input logic [31:0] addr);
    int a;
    a = int'(addr % 4);
    if (sz == SZ_BYTE) return 4'(1 << a);
    if (sz == SZ_HALF) return (a == 0) ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction

  function automatic logic [31:0] refWData(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == SZ_BYTE) return (sd % 256) * 32'h01010101;
    if (sz == SZ_HALF) return (sd % 65536) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] refLoad(input logic isRead, input logic [1:0] sz, input logic uns,
                                          input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    int a;
    if (!isRead) return 32'd0;
    a = int'(addr % 4);
    if (sz == SZ_BYTE) begin
      v = (rd / (32'd1 << (8 * a))) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
      return v;
    end
    if (sz == SZ_HALF) begin
      v = (rd / (32'd1 << (8 * a))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
      return v;
    end
    return rd;
  endfunction

  // Drives one instruction through the stage and records what the bus and pipeline saw
  task automatic doTransaction(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                               input int ackDelay, input logic spurious);
    logic first;
    stallCyc = 0; reqCyc = 0; obsAddr = '0; obsBe = '0; obsWe = 1'b0; obsWData = '0;
    obsLoad = '0; obsErr = 1'b0; obsMis = 1'b0; obsStable = 1'b1; finished = 1'b0; first = 1'b1;
    @(negedge clk);
    memReadIn = rd; memWriteIn = wr; sizeIn = sz; unsignedIn = uns;
    addrIn = addr; storeDataIn = sd; busRData = rdata; busAck = spurious;
    for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
      #1;
      if (misalignOut) obsMis = 1'b1;
      if (errOut) obsErr = 1'b1;
      if (busReq) begin
        if (first) begin
          obsAddr = busAddr; obsBe = busBe; obsWe = busWe; obsWData = busWData;
          first = 1'b0;
        end else if (busAddr !== obsAddr || busBe !== obsBe || busWe !== obsWe || busWData !== obsWData) begin
          obsStable = 1'b0;
        end
        reqCyc++;
      end
      if (stallOut) begin
        stallCyc++;
        if (busReq) busAck = (reqCyc - 1 == ackDelay);
        else busAck = (cyc == 0) ? spurious : 1'b0;
        @(negedge clk);
      end else begin
        obsLoad = loadDataOut;
        finished = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    memReadIn = 1'b0; memWriteIn = 1'b0; busAck = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({stallOut, misalignOut, errOut, busReq, busWe} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b want=00000", {stallOut, misalignOut, errOut, busReq, busWe});
    end
    checks++;
    if (loadDataOut !== 32'd0 || busAddr !== 32'd0 || busWData !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_data load=%h addr=%h wdata=%h want=0", loadDataOut, busAddr, busWData);
    end
    checks++;
    if (busBe !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_be got=%b want=0000", busBe);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word_read();
    doTransaction(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    checks++;
    if (reqCyc != 1 || stallCyc != 2) begin
      failures++;
      $display("[TB] FAIL word_read_timing req=%0d stall=%0d want req=1 stall=2", reqCyc, stallCyc);
    end
    checks++;
    if (obsAddr !== 32'h100 || obsBe !== 4'b1111 || obsWe !== 1'b0) begin
      failures++;
      $display("[TB] FAIL word_read_bus addr=%h be=%b we=%b want 100/1111/0", obsAddr, obsBe, obsWe);
    end
    checks++;
    if (obsLoad !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL word_read_data got=%h want=deadbeef", obsLoad);
    end
  endtask

  task automatic test_byte_load();
    doTransaction(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 32'h80123456, 1, 1'b0);
    checks++;
    if (obsBe !== 4'b1000 || obsAddr !== 32'h100) begin
      failures++;
      $display("[TB] FAIL lb_bus be=%b addr=%h want 1000/100", obsBe, obsAddr);
    end
    checks++;
    if (obsLoad !== 32'hFFFFFF80) begin
      failures++;
      $display("[TB] FAIL lb_data got=%h want=ffffff80", obsLoad);
    end
    doTransaction(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 32'h80123456, 0, 1'b0);
    checks++;
    if (obsLoad !== 32'h00000080) begin
      failures++;
      $display("[TB] FAIL lbu_data got=%h want=00000080", obsLoad);
    end
  endtask

  task automatic test_half_store();
    doTransaction(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h102, 32'h0000ABCD, 32'h12345678, 0, 1'b0);
    checks++;
    if (obsWe !== 1'b1 || obsBe !== 4'b1100 || obsWData !== 32'hABCDABCD) begin
      failures++;
      $display("[TB] FAIL sh_bus we=%b be=%b wdata=%h want 1/1100/abcdabcd", obsWe, obsBe, obsWData);
    end
    checks++;
    if (obsLoad !== 32'd0) begin
      failures++;
      $display("[TB] FAIL sh_load got=%h want=0", obsLoad);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [2];
    logic [1:0]  sizes [2];
    addrs[0] = 32'h101; sizes[0] = SZ_WORD;
    addrs[1] = 32'h003; sizes[1] = SZ_HALF;
    for (int i = 0; i < 2; i++) begin
      doTransaction(1'b1, 1'b0, sizes[i], 1'b0, addrs[i], 32'h0, 32'hFFFFFFFF, 0, 1'b0);
      checks++;
      if (obsMis !== 1'b1 || reqCyc != 0 || stallCyc != 0 || obsLoad !== 32'd0) begin
        failures++;
        $display("[TB] FAIL misalign_%0d mis=%b req=%0d stall=%0d load=%h want 1/0/0/0",
                 i, obsMis, reqCyc, stallCyc, obsLoad);
      end
    end
  endtask

  task automatic test_timeout();
    doTransaction(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h55555555, -1, 1'b0);
    checks++;
    if (reqCyc != TB_TIMEOUT || stallCyc != TB_TIMEOUT + 1) begin
      failures++;
      $display("[TB] FAIL timeout_len req=%0d stall=%0d want req=%0d stall=%0d",
               reqCyc, stallCyc, TB_TIMEOUT, TB_TIMEOUT + 1);
    end
    checks++;
    if (obsErr !== 1'b1 || obsLoad !== 32'd0 || finished !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_err err=%b load=%h done=%b want 1/0/1", obsErr, obsLoad, finished);
    end
    @(negedge clk);
    checks++;
    if (stallOut !== 1'b0 || errOut !== 1'b0 || busReq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_idle stall=%b err=%b req=%b want 000", stallOut, errOut, busReq);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    memReadIn = 1'b1; sizeIn = SZ_WORD; addrIn = 32'h200; busAck = 1'b0; busRData = 32'hCAFEF00D;
    @(negedge clk);
    #1;
    checks++;
    if (busReq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_pre got=%b want=1", busReq);
    end
    rst = 1'b1; memReadIn = 1'b0;
    #1;
    checks++;
    if (busReq !== 1'b0 || stallOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid_async req=%b stall=%b want 00", busReq, stallOut);
    end
    @(negedge clk);
    rst = 1'b0; busAck = 1'b1;
    @(negedge clk);
    busAck = 1'b0;
    #1;
    checks++;
    if ({busReq, stallOut, errOut, busWe, busBe} !== 8'd0 || loadDataOut !== 32'd0 || busAddr !== 32'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid_after req=%b stall=%b err=%b be=%b load=%h addr=%h want 0",
               busReq, stallOut, errOut, busBe, loadDataOut, busAddr);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int          op;
      logic        rd, wr, uns, spur, ok;
      logic [1:0]  sz;
      logic [31:0] addr, sd, rdata;
      int          dly;
      op = int'($urandom_range(1, 3));
      rd = (op != 2); wr = (op != 1);
      sz = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      addr = $urandom; sd = $urandom; rdata = $urandom;
      dly = int'($urandom_range(0, TB_TIMEOUT - 1));
      spur = 1'($urandom_range(0, 1));
      ok = refAligned(sz, addr);
      doTransaction(rd, wr, sz, uns, addr, sd, rdata, dly, spur);
      checks++;
      if (obsMis !== !ok || stallCyc != (ok ? dly + 2 : 0) || reqCyc != (ok ? dly + 1 : 0) || !finished) begin
        failures++;
        $display("[TB] FAIL rand_flow n=%0d mis=%b stall=%0d req=%0d want mis=%b stall=%0d req=%0d",
                 n, obsMis, stallCyc, reqCyc, !ok, ok ? dly + 2 : 0, ok ? dly + 1 : 0);
      end
      if (ok) begin
        checks++;
        if (obsAddr !== (addr - addr % 4) || obsBe !== refBe(sz, addr) || obsWe !== !rd || !obsStable) begin
          failures++;
          $display("[TB] FAIL rand_bus n=%0d addr=%h be=%b we=%b stable=%b want %h/%b/%b/1",
                   n, obsAddr, obsBe, obsWe, obsStable, addr - addr % 4, refBe(sz, addr), !rd);
        end
        if (!rd) begin
          checks++;
          if (obsWData !== refWData(sz, sd)) begin
            failures++;
            $display("[TB] FAIL rand_wdata n=%0d got=%h want=%h", n, obsWData, refWData(sz, sd));
          end
        end
        checks++;
        if (obsLoad !== refLoad(rd, sz, uns, addr, rdata) || obsErr !== 1'b0) begin
          failures++;
          $display("[TB] FAIL rand_load n=%0d got=%h err=%b want=%h err=0",
                   n, obsLoad, obsErr, refLoad(rd, sz, uns, addr, rdata));
        end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; memReadIn = 1'b0; memWriteIn = 1'b0; sizeIn = SZ_BYTE; unsignedIn = 1'b0;
    addrIn = 32'd0; storeDataIn = 32'd0; busAck = 1'b0; busRData = 32'd0;
    repeat (2) @(posedge clk);
    test_reset();
    test_word_read();
    test_byte_load();
    test_half_store();
    test_misalign();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
